// File: rtl/cpu_clock_sequencer.sv
// rtl/cpu_clock_sequencer.sv - CPU clock/reset generator with run, halt and single-step control
// Buttons are synchronised, debounced and edge-detected before they reach the mode FSM.
module cpu_clock_sequencer #(
  parameter int PAR_CLOCK    = 10_000_000,
  parameter int DEBOUNCE     = 1_000_000,
  parameter int RESET_PULSES = 4,
  parameter int CNT_W        = 32
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        BTN_MODE,
  input  logic        BTN_STEP,
  input  logic        BTN_RST,
  output logic        CPU_CLOCK,
  output logic        CPU_RESET,
  output logic [1:0]  MODE,
  output logic [15:0] CYCLE_COUNT
);

  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_HALT  = 2'b01,
    S_RUN   = 2'b10,
    S_STEP  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] PH_LAST = CNT_W'(PAR_CLOCK - 1);
  localparam logic [CNT_W-1:0] PH_HALF = CNT_W'(PAR_CLOCK / 2);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(RESET_PULSES - 1);

  // Bit 0 = mode, bit 1 = step, bit 2 = rst
  logic [2:0]       btn_raw;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       level;
  logic [2:0]       level_d;
  logic [2:0]       press;
  logic [CNT_W-1:0] db_cnt [3];

  assign btn_raw = {BTN_RST, BTN_STEP, BTN_MODE};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  state_t           state, state_nx;
  logic [CNT_W-1:0] ph, ph_nx;
  logic [CNT_W-1:0] pulse_cnt, pulse_cnt_nx;
  logic             stop_pending, stop_pending_nx;
  logic             clk_out, clk_out_nx;
  logic             rst_out, rst_out_nx;
  logic [15:0]      cycle_cnt, cycle_cnt_nx;
  logic             wrap;
  logic [CNT_W-1:0] ph_inc;

  assign wrap   = (ph == PH_LAST);
  assign ph_inc = wrap ? '0 : ph + 1'b1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= S_RESET;
      ph           <= '0;
      pulse_cnt    <= '0;
      stop_pending <= 1'b0;
      clk_out      <= 1'b0;
      rst_out      <= 1'b1;
      cycle_cnt    <= '0;
    end else begin
      state        <= state_nx;
      ph           <= ph_nx;
      pulse_cnt    <= pulse_cnt_nx;
      stop_pending <= stop_pending_nx;
      clk_out      <= clk_out_nx;
      rst_out      <= rst_out_nx;
      cycle_cnt    <= cycle_cnt_nx;
    end
  end

  always_comb begin
    state_nx        = state;
    ph_nx           = ph;
    pulse_cnt_nx    = pulse_cnt;
    stop_pending_nx = stop_pending;
    rst_out_nx      = rst_out;
    cycle_cnt_nx    = cycle_cnt;

    case (state)
      S_RESET: begin
        ph_nx = ph_inc;
        if (wrap) begin
          if (pulse_cnt == RP_LAST) begin
            state_nx     = S_HALT;
            rst_out_nx   = 1'b0;
            cycle_cnt_nx = '0;
            pulse_cnt_nx = '0;
          end else begin
            pulse_cnt_nx = pulse_cnt + 1'b1;
          end
        end
      end
      S_HALT: begin
        ph_nx = '0;
        if (press[0]) state_nx = S_RUN;
        else if (press[1]) state_nx = S_STEP;
      end
      S_RUN: begin
        ph_nx = ph_inc;
        // Stop only at the wrap so the CPU never sees a shortened high phase
        if (wrap && (stop_pending || press[0])) begin
          state_nx        = S_HALT;
          stop_pending_nx = 1'b0;
        end else if (press[0]) begin
          stop_pending_nx = 1'b1;
        end
      end
      S_STEP: begin
        ph_nx = ph_inc;
        if (wrap) state_nx = S_HALT;
      end
      default: state_nx = S_RESET;
    endcase

    clk_out_nx = (ph_nx >= PH_HALF);
    if (!rst_out && clk_out_nx && !clk_out) cycle_cnt_nx = cycle_cnt + 16'd1;

    if (press[2]) begin
      state_nx        = S_RESET;
      ph_nx           = '0;
      clk_out_nx      = 1'b0;
      rst_out_nx      = 1'b1;
      pulse_cnt_nx    = '0;
      stop_pending_nx = 1'b0;
      cycle_cnt_nx    = cycle_cnt;
    end
  end

  assign CPU_CLOCK   = clk_out;
  assign CPU_RESET   = rst_out;
  assign MODE        = state;
  assign CYCLE_COUNT = cycle_cnt;

endmodule

// File: tb/tb_cpu_clock_sequencer.sv
// tb/tb_cpu_clock_sequencer.sv - scoreboard bench for cpu_clock_sequencer
// Expected mode transitions are queued by the stimulus and checked by a negedge monitor.
module tb_cpu_clock_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn_mode = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_rst = 1'b0;
  logic        cpu_clock;
  logic        cpu_reset;
  logic [1:0]  mode;
  logic [15:0] cycle_count;

  cpu_clock_sequencer #(
    .PAR_CLOCK(10),
    .DEBOUNCE(4),
    .RESET_PULSES(2),
    .CNT_W(32)
  ) dut (
    .CLK(clk),
    .RESET_N(rst_n),
    .BTN_MODE(btn_mode),
    .BTN_STEP(btn_step),
    .BTN_RST(btn_rst),
    .CPU_CLOCK(cpu_clock),
    .CPU_RESET(cpu_reset),
    .MODE(mode),
    .CYCLE_COUNT(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         cc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [1:0]  last_mode = 2'b00;
  logic        clk_prev = 1'b0;
  logic        rst_prev = 1'b1;
  int          hi_w = 0;
  int          rise_cnt = 0;
  logic [15:0] ref_cc = 16'd0;

  task automatic chk(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [1:0] m, input int cc);
    exp_t e;
    e.mode = m;
    e.cc   = cc;
    exp_q.push_back(e);
  endtask

  task automatic monitor_step();
    exp_t e;
    int   want_cc;
    if (!rst_n) begin
      ref_cc   = 16'd0;
      hi_w     = 0;
      rst_prev = 1'b1;
    end else begin
      if (rst_prev && !cpu_reset) ref_cc = 16'd0;
      if (cpu_clock && !clk_prev) begin
        rise_cnt++;
        if (!cpu_reset) ref_cc = ref_cc + 16'd1;
      end
      if (cpu_clock) begin
        hi_w++;
      end else if (hi_w != 0) begin
        chk("high_width", hi_w, 5);
        hi_w = 0;
      end
      rst_prev = cpu_reset;
    end
    clk_prev = cpu_clock;
    if (mode != last_mode) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_mode: got %0d expected %0d", mode, last_mode);
      end else begin
        e = exp_q.pop_front();
        want_cc = (e.cc < 0) ? int'(ref_cc) : e.cc;
        chk("sb_mode", mode, e.mode);
        chk("sb_cycle_count", cycle_count, want_cc);
        chk("sb_cpu_clock", cpu_clock, 0);
        chk("sb_cpu_reset", cpu_reset, (mode == 2'b00) ? 1 : 0);
      end
      last_mode = mode;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m, input int n);
    {btn_rst, btn_step, btn_mode} = m;
    repeat (n) @(negedge clk);
    {btn_rst, btn_step, btn_mode} = 3'b000;
  endtask

  task automatic wait_mode(input logic [1:0] m);
    int k = 0;
    while (mode != m && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_mode", mode, m);
  endtask

  task automatic wait_clk(input logic v);
    int k = 0;
    while (cpu_clock != v && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("wait_cpu_clock", cpu_clock, v);
  endtask

  task automatic wait_rises(input int target);
    int k = 0;
    while (rise_cnt < target && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("wait_rises", rise_cnt, target);
  endtask

  task automatic measure_reset();
    int   n = 0;
    int   hs = 0;
    int   rises = 0;
    logic prev = 1'b0;
    while (cpu_reset && n < 100) begin
      n++;
      if (cpu_clock) hs++;
      if (cpu_clock && !prev) rises++;
      prev = cpu_clock;
      @(negedge clk);
    end
    chk("reset_len", n, 20);
    chk("reset_high_clks", hs, 10);
    chk("reset_pulses", rises, 2);
    chk("post_reset_mode", mode, 1);
    chk("post_reset_clock", cpu_clock, 0);
    chk("post_reset_count", cycle_count, 0);
  endtask

  initial begin
    int p;
    #1 rst_n = 1'b0;
    fork
      forever begin
        @(negedge clk);
        monitor_step();
      end
    join_none

    // Reset state and power-on sequencing
    repeat (3) @(negedge clk);
    chk("rst_cpu_clock", cpu_clock, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_mode", mode, 0);
    chk("rst_count", cycle_count, 0);
    push(2'b01, 0);
    rst_n = 1'b1;
    measure_reset();
    idle(5);

    // Run, then stop requested in the middle of a high half
    p = rise_cnt;
    push(2'b10, 0);
    press(3'b001, 10);
    wait_rises(p + 3);
    wait_clk(1'b0);
    chk("run_3_periods", cycle_count, 3);
    push(2'b01, 4);
    press(3'b001, 10);
    wait_mode(2'b01);
    chk("stop_full_pulse", rise_cnt, p + 4);
    idle(10);

    // Step glitch is filtered, then a real single step
    p = rise_cnt;
    press(3'b010, 3);
    idle(20);
    chk("glitch_mode", mode, 1);
    chk("glitch_no_pulse", rise_cnt, p);
    push(2'b11, 4);
    push(2'b01, 5);
    press(3'b010, 10);
    idle(30);
    chk("step_mode", mode, 1);
    chk("step_one_pulse", rise_cnt, p + 1);
    chk("step_count", cycle_count, 5);

    // Mode and step together: mode wins
    p = rise_cnt;
    push(2'b10, 5);
    press(3'b011, 10);
    wait_mode(2'b10);
    chk("both_no_step", rise_cnt, p);
    idle(10);
    wait_clk(1'b1);
    wait_clk(1'b0);
    push(2'b01, int'(ref_cc) + 1);
    press(3'b001, 10);
    wait_mode(2'b01);
    idle(10);

    // Second step press while stepping is ignored
    p = rise_cnt;
    push(2'b11, int'(ref_cc));
    push(2'b01, int'(ref_cc) + 1);
    press(3'b010, 5);
    idle(4);
    press(3'b010, 4);
    idle(30);
    chk("step_in_step_mode", mode, 1);
    chk("step_in_step_pulse", rise_cnt, p + 1);

    // Reset button while running
    push(2'b10, int'(ref_cc));
    press(3'b001, 10);
    wait_mode(2'b10);
    idle(10);
    push(2'b00, -1);
    push(2'b01, 0);
    btn_rst = 1'b1;
    fork
      begin
        repeat (10) @(negedge clk);
        btn_rst = 1'b0;
      end
    join_none
    wait_mode(2'b00);
    measure_reset();
    idle(10);

    // Asynchronous reset during a high phase
    push(2'b10, 0);
    press(3'b001, 10);
    wait_mode(2'b10);
    wait_clk(1'b1);
    push(2'b00, 0);
    rst_n = 1'b0;
    #1;
    chk("async_cpu_clock", cpu_clock, 0);
    chk("async_cpu_reset", cpu_reset, 1);
    chk("async_mode", mode, 0);
    chk("async_count", cycle_count, 0);
    repeat (3) @(negedge clk);
    push(2'b01, 0);
    rst_n = 1'b1;
    measure_reset();
    idle(10);

    // Cycle counter wrap across two steps
    force dut.cycle_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.cycle_cnt;
    @(negedge clk);
    chk("preload", cycle_count, 16'hFFFE);
    push(2'b11, 16'hFFFE);
    push(2'b01, 16'hFFFF);
    press(3'b010, 10);
    idle(30);
    push(2'b11, 16'hFFFF);
    push(2'b01, 0);
    press(3'b010, 10);
    idle(30);
    chk("wrap_count", cycle_count, 0);
    chk("wrap_mode", mode, 1);

    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
